mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side signals of the arbiter.
// slave  : the arbiter's view (takes requests, drives memory commands).
// master : the environment's view (caches plus memory model).
interface mem_arbiter_if;
    // I-cache side
    logic         i_read;
    logic [27:0]  i_addr;
    logic [127:0] i_rdata;
    logic         i_ready;
    // D-cache side
    logic         d_read;
    logic         d_write;
    logic [27:0]  d_addr;
    logic [127:0] d_wdata;
    logic [127:0] d_rdata;
    logic         d_ready;
    // Memory side
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    // Status
    logic         busy;

    modport slave (
        input  i_read, i_addr,
        output i_rdata, i_ready,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output busy
    );

    modport master (
        output i_read, i_addr,
        input  i_rdata, i_ready,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: I-cache and D-cache share one block-wide memory
// port. One transaction at a time; simultaneous requests alternate using a
// last-grant bit. All memory commands and cache responses are registered.
module mem_arbiter (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t       r_state;
    state_t       w_state_next;
    logic         r_last_grant;
    logic         w_last_grant_next;

    logic         r_mem_read,   w_mem_read_next;
    logic         r_mem_write,  w_mem_write_next;
    logic [27:0]  r_mem_addr,   w_mem_addr_next;
    logic [127:0] r_mem_wdata,  w_mem_wdata_next;
    logic [127:0] r_i_rdata,    w_i_rdata_next;
    logic [127:0] r_d_rdata,    w_d_rdata_next;
    logic         r_i_ready,    w_i_ready_next;
    logic         r_d_ready,    w_d_ready_next;

    logic         w_d_req;
    logic         w_grant_d;
    logic         w_grant_i;

    // Arbitration: D wins if alone, or on a tie when I was granted last.
    assign w_d_req   = bus.d_read | bus.d_write;
    assign w_grant_d = w_d_req & (~bus.i_read | (r_last_grant == GRANT_I));
    assign w_grant_i = bus.i_read & ~w_grant_d;

    // State and last-grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_I;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    // Next-state and next values for every registered output.
    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_mem_read_next   = r_mem_read;
        w_mem_write_next  = r_mem_write;
        w_mem_addr_next   = r_mem_addr;
        w_mem_wdata_next  = r_mem_wdata;
        w_i_rdata_next    = r_i_rdata;
        w_d_rdata_next    = r_d_rdata;
        w_i_ready_next    = 1'b0;
        w_d_ready_next    = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_next      = SERVE_D;
                    w_last_grant_next = GRANT_D;
                    w_mem_addr_next   = bus.d_addr;
                    // A combined read+write request is a write.
                    if (bus.d_write) begin
                        w_mem_write_next = 1'b1;
                        w_mem_wdata_next = bus.d_wdata;
                    end else begin
                        w_mem_read_next  = 1'b1;
                    end
                end else if (w_grant_i) begin
                    w_state_next      = SERVE_I;
                    w_last_grant_next = GRANT_I;
                    w_mem_addr_next   = bus.i_addr;
                    w_mem_read_next   = 1'b1;
                end
            end
            SERVE_I: begin
                if (bus.mem_ready) begin
                    w_state_next     = RESP;
                    w_mem_read_next  = 1'b0;
                    w_mem_write_next = 1'b0;
                    w_i_ready_next   = 1'b1;
                    w_i_rdata_next   = bus.mem_rdata;
                end
            end
            SERVE_D: begin
                if (bus.mem_ready) begin
                    w_state_next     = RESP;
                    w_mem_read_next  = 1'b0;
                    w_mem_write_next = 1'b0;
                    w_d_ready_next   = 1'b1;
                    // Write completions leave the read data untouched.
                    if (!r_mem_write) begin
                        w_d_rdata_next = bus.mem_rdata;
                    end
                end
            end
            RESP: begin
                // Requests are not sampled here: one cycle to drop them.
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Registered memory command and cache response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_ready   <= 1'b0;
            r_d_ready   <= 1'b0;
        end else begin
            r_mem_read  <= w_mem_read_next;
            r_mem_write <= w_mem_write_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_i_rdata   <= w_i_rdata_next;
            r_d_rdata   <= w_d_rdata_next;
            r_i_ready   <= w_i_ready_next;
            r_d_ready   <= w_d_ready_next;
        end
    end

    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.i_ready   = r_i_ready;
    assign bus.d_ready   = r_d_ready;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a scoreboard of expected memory
// transactions (pushed when a request is raised, popped when the arbiter
// issues the memory command), with a simple memory responder.
module tb_mem_arbiter;

    logic clk;
    logic rst_n;

    mem_arbiter_if bus ();

    mem_arbiter u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           is_d;
        bit           is_write;
        logic [27:0]  addr;
        logic [127:0] wdata;
    } txn_t;

    txn_t         exp_q[$];
    logic [127:0] last_i;
    logic [127:0] last_d;
    int           n_vec;
    int           n_err;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {155'd0, bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready, bus.busy}, 160'd0);
        check({tag, "_mem_addr"}, {132'd0, bus.mem_addr}, 160'd0);
        check({tag, "_mem_wdata"}, {32'd0, bus.mem_wdata}, 160'd0);
        check({tag, "_i_rdata"}, {32'd0, bus.i_rdata}, 160'd0);
        check({tag, "_d_rdata"}, {32'd0, bus.d_rdata}, 160'd0);
    endtask

    task automatic req_i(input logic [27:0] addr);
        txn_t t;
        bus.i_read = 1'b1;
        bus.i_addr = addr;
        t.is_d = 1'b0; t.is_write = 1'b0; t.addr = addr; t.wdata = '0;
        exp_q.push_back(t);
    endtask

    task automatic req_d(input logic [27:0] addr, input logic rd, input logic wr, input logic [127:0] wdata);
        txn_t t;
        bus.d_read  = rd;
        bus.d_write = wr;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        t.is_d = 1'b1; t.is_write = wr; t.addr = addr; t.wdata = wr ? wdata : 128'd0;
        exp_q.push_back(t);
    endtask

    // Wait (bounded) for a memory command; it must appear one cycle after
    // the IDLE sample, and must match the oldest scoreboard entry.
    task automatic wait_cmd(output txn_t t);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.mem_read || bus.mem_write) && n < 50);
        check("cmd_latency", 160'(n), 160'd1);
        check("sb_pending", 160'(exp_q.size() != 0), 160'd1);
        if (exp_q.size() != 0) t = exp_q.pop_front();
        else begin t.is_d = 0; t.is_write = 0; t.addr = '0; t.wdata = '0; end
        check("cmd_kind_addr", {130'd0, bus.mem_write, bus.mem_read, bus.mem_addr},
              {130'd0, t.is_write, ~t.is_write, t.addr});
    endtask

    // Hold the command for 'delay' cycles, pulse mem_ready, check the
    // response pulse and data, then check the return to IDLE.
    task automatic complete(input txn_t t, input int delay, input logic [127:0] rd,
                            input bit drop, output int held);
        logic [127:0] exp_i, exp_d;
        held = 0;
        for (int c = 1; c <= delay; c++) begin
            if (bus.mem_read || bus.mem_write) held++;
            check("cmd_stable", {2'd0, bus.mem_read, bus.mem_write, bus.mem_addr,
                                 t.is_write ? bus.mem_wdata : 128'd0},
                  {2'd0, ~t.is_write, t.is_write, t.addr, t.wdata});
            check("no_early_ready", {158'd0, bus.i_ready, bus.d_ready}, 160'd0);
            if (c < delay) @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        exp_i = last_i;
        exp_d = last_d;
        if (t.is_d && !t.is_write) exp_d = rd;
        if (!t.is_d) exp_i = rd;
        last_i = exp_i;
        last_d = exp_d;
        check("ready_pulse", {158'd0, bus.i_ready, bus.d_ready}, {158'd0, ~t.is_d, t.is_d});
        check("cmd_cleared", {158'd0, bus.mem_read, bus.mem_write}, 160'd0);
        check("i_rdata", {32'd0, bus.i_rdata}, {32'd0, exp_i});
        check("d_rdata", {32'd0, bus.d_rdata}, {32'd0, exp_d});
        $display("txn %s %s addr=%07h data=%032h", t.is_d ? "D" : "I",
                 t.is_write ? "WR" : "RD", t.addr, t.is_write ? t.wdata : rd);
        if (drop) begin
            if (t.is_d) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
            else bus.i_read = 1'b0;
        end
        @(negedge clk);
        check("idle_after_resp", {157'd0, bus.i_ready, bus.d_ready, bus.busy}, 160'd0);
    endtask

    initial begin
        txn_t t;
        int   held;
        n_vec = 0;
        n_err = 0;
        last_i = '0;
        last_d = '0;
        rst_n = 1'b0;
        bus.i_read = 0; bus.i_addr = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Stray mem_ready in IDLE is ignored
        bus.mem_ready = 1'b1;
        bus.mem_rdata = {4{32'hFFFF_0000}};
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        check("stray_ctl", {155'd0, bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready, bus.busy}, 160'd0);
        check("stray_rdata", {bus.i_rdata[79:0], bus.d_rdata[79:0]}, {last_i[79:0], last_d[79:0]});
        @(negedge clk);
        check("stray_busy", {159'd0, bus.busy}, 160'd0);

        // Tie after reset: D first; D re-requests while I waits -> I, then D
        req_d(28'h0000A00, 1'b1, 1'b0, '0);
        req_i(28'h0000B00);
        wait_cmd(t); complete(t, 2, {4{32'hD1D1_D1D1}}, 1'b0, held);
        req_d(28'h0000A40, 1'b1, 1'b0, '0);
        wait_cmd(t); complete(t, 2, {4{32'h1111_2222}}, 1'b1, held);
        wait_cmd(t); complete(t, 1, {4{32'hD2D2_0000}}, 1'b1, held);

        // I read, mem_ready in the fourth command cycle
        req_i(28'h0123450);
        wait_cmd(t); complete(t, 4, {16{8'hA5}}, 1'b1, held);
        check("mem_read_cycles", 160'(held), 160'd4);

        // D write: d_rdata must not change
        req_d(28'h0000010, 1'b0, 1'b1, 128'h1234);
        wait_cmd(t); complete(t, 3, 128'hDEAD_BEEF, 1'b1, held);

        // Read+write together is a write; I raised during SERVE_D waits
        req_d(28'h0000020, 1'b1, 1'b1, {4{32'h5678_9ABC}});
        wait_cmd(t);
        req_i(28'h0000030);
        complete(t, 3, 128'hBAD0, 1'b1, held);
        wait_cmd(t); complete(t, 1, {4{32'h3030_3030}}, 1'b1, held);

        // Reset during SERVE_I abandons the transaction
        req_i(28'h0000300);
        wait_cmd(t);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 last_i = '0; last_d = '0;
        check_zero("async_reset");
        bus.i_read = 1'b0;
        @(negedge clk);
        check_zero("reset_hold");
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {158'd0, bus.busy, bus.i_ready}, 160'd0);
        req_i(28'h0000340);
        wait_cmd(t); complete(t, 2, {4{32'hCAFE_F00D}}, 1'b1, held);

        // Minimum-latency D read
        req_d(28'h0FFFFFF, 1'b1, 1'b0, '0);
        wait_cmd(t); complete(t, 1, {4{32'h0BAD_CAFE}}, 1'b1, held);

        check("sb_drained", 160'(exp_q.size()), 160'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Ready pulses and memory commands must never overlap.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.i_ready && bus.d_ready) begin
                n_vec++;
                n_err++;
                $error("FAIL ready_overlap: observed 11 expected not both");
            end
            if (bus.mem_read && bus.mem_write) begin
                n_vec++;
                n_err++;
                $error("FAIL cmd_overlap: observed 11 expected not both");
            end
        end
    end

endmodule
